// File: rtl/alu_sched_pkg.sv
// Shared constants for the ALU scheduler: default sizing, operand/opcode widths
// and the FSM state encoding.
package alu_sched_pkg;

  localparam int DEF_NREQ    = 4;
  localparam int DEF_ALU_LAT = 2;
  localparam int OP_W        = 3;
  localparam int DATA_W      = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester found
// after last_grant, wrapping past N-1 back to 0.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last_grant,
  output logic [N-1:0]   grant
);

  // Walk the ring starting just after last_grant; the first requester seen wins.
  always_comb begin : arb
    logic           found;
    logic [IDW-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx        = IDW'((int'(last_grant) + k) % N);
      grant[idx] = req[idx] & ~found;
      found      = found | req[idx];
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one pipelined ALU among NREQ requesters: round-robin accept, wait
// ALU_LAT cycles for the result, then hold a response until it is taken.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int ALU_LAT = DEF_ALU_LAT,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [DATA_W*NREQ-1:0] req_a,
  input  logic [DATA_W*NREQ-1:0] req_b,
  input  logic [OP_W*NREQ-1:0]   req_op,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [OP_W-1:0]        alu_op,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic                   alu_carry,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [DATA_W-1:0]      rsp_result,
  output logic                   rsp_carry,
  output logic                   busy
);

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] gidx;
  logic [2:0]     cnt;
  logic [NREQ-1:0] grant;
  logic           accept;

  logic [DATA_W-1:0] a_arr  [NREQ];
  logic [DATA_W-1:0] b_arr  [NREQ];
  logic [OP_W-1:0]   op_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign a_arr[g]  = req_a[g*DATA_W +: DATA_W];
    assign b_arr[g]  = req_b[g*DATA_W +: DATA_W];
    assign op_arr[g] = req_op[g*OP_W +: OP_W];
  end

  rr_arbiter #(.N(NREQ), .IDW(IDW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Offer the grant only while idle and out of reset, so req_ready is low during reset.
  assign req_ready = ((state == ST_IDLE) && rst_n) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RESP);

  // Encode the one-hot grant into the winning requester index.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      gidx = grant[i] ? IDW'(i) : gidx;
    end
  end

  // Scheduler FSM: operands, latency counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= IDW'(NREQ - 1);
      cnt        <= 3'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            alu_a  <= a_arr[gidx];
            alu_b  <= b_arr[gidx];
            alu_op <= op_arr[gidx];
            rsp_id <= gidx;
            cnt    <= 3'(ALU_LAT);
            state  <= ST_EXEC;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          // Last counted cycle: the ALU output now reflects the issued operands.
          if (cnt == 3'd1) begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
            cnt        <= 3'd0;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            last_grant <= rsp_id;
            state      <= ST_IDLE;
          end else begin
            state <= ST_RESP;
          end
        end
        default: begin
          cnt   <= 3'd0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Randomised self-checking bench for alu_sched: a behavioural ALU drives the
// datapath and a transaction-level scoreboard predicts grants and responses.
module tb_alu_sched;

  localparam int NREQ    = 4;
  localparam int ALU_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = 4'h0;
  logic [3:0]  req_ready;
  logic [15:0] req_a = 16'h0;
  logic [15:0] req_b = 16'h0;
  logic [11:0] req_op = 12'h0;
  logic [3:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [3:0]  alu_result;
  logic        alu_carry;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_result;
  logic        rsp_carry;
  logic        busy;

  alu_sched #(.NREQ(NREQ), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: {carry, result}; op 0 add, 1 subtract (carry = borrow).
  function automatic logic [4:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      default: return {1'b0, ~a};
    endcase
  endfunction

  // One register stage: the result is valid ALU_LAT (=2) edges after issue, stale before.
  logic [4:0] alu_pipe = 5'h0;
  always @(posedge clk) alu_pipe <= alu_f(alu_op, alu_a, alu_b);
  assign alu_result = alu_pipe[3:0];
  assign alu_carry  = alu_pipe[4];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int         id;
    logic [4:0] rc;
    int         acc;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         last_acc = -100;
  int         model_last = NREQ - 1;
  int         acc_count = 0;
  int         rsp_count = 0;
  int         served[NREQ];
  int         acc_id_log[$];
  int         acc_cyc_log[$];
  int         last_id = -1;
  logic [4:0] last_rc = 5'h0;

  function automatic int winner(input logic [3:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    logic        prev_rv;
    logic [10:0] exp_alu;
    logic [3:0]  exp_rdy;
    int          g;
    exp_t        e;
    prev_rv = 1'b0;
    exp_alu = 11'h0;
    for (int i = 0; i < NREQ; i++) served[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("rst_outs", {alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_carry, req_ready, busy}, 32'h0);
        q.delete();
        model_last = NREQ - 1;
        last_acc   = -100;
        prev_rv    = 1'b0;
        exp_alu    = 11'h0;
      end else begin
        chk("alu_hold", {alu_op, alu_a, alu_b}, exp_alu);
        chk("busy", busy, q.size() != 0);
        if (q.size() == 0) begin
          exp_rdy = 4'h0;
          if (req_valid != 4'h0) exp_rdy = 4'(1 << winner(req_valid, model_last));
          chk("req_ready", req_ready, exp_rdy);
        end else begin
          chk("ready_busy", req_ready, 4'h0);
        end
        if (rsp_valid) begin
          if (q.size() == 0) begin
            chk("spurious_rsp", 1'b1, 1'b0);
          end else begin
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_data", {rsp_carry, rsp_result}, q[0].rc);
            if (!prev_rv) chk("rsp_lat", cyc - q[0].acc, ALU_LAT + 1);
            if (rsp_ready) begin
              model_last = q[0].id;
              served[q[0].id]++;
              last_id = q[0].id;
              last_rc = {rsp_carry, rsp_result};
              rsp_count++;
              void'(q.pop_front());
            end
          end
        end else if (q.size() != 0) begin
          chk("rsp_late", (cyc - q[0].acc) <= ALU_LAT, 1'b1);
        end
        prev_rv = rsp_valid;
        if ((req_valid & req_ready) != 4'h0) begin
          g = 0;
          for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
          chk("one_flight", q.size(), 0);
          if (last_acc >= 0) chk("spacing", (cyc - last_acc) >= ALU_LAT + 2, 1'b1);
          e.id  = g;
          e.acc = cyc;
          e.rc  = alu_f(3'(req_op >> (3 * g)), 4'(req_a >> (4 * g)), 4'(req_b >> (4 * g)));
          q.push_back(e);
          exp_alu  = {3'(req_op >> (3 * g)), 4'(req_a >> (4 * g)), 4'(req_b >> (4 * g))};
          last_acc = cyc;
          acc_count++;
          acc_id_log.push_back(g);
          acc_cyc_log.push_back(cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    req_a  = (req_a  & ~(16'hF << (4 * i))) | (16'(a)  << (4 * i));
    req_b  = (req_b  & ~(16'hF << (4 * i))) | (16'(b)  << (4 * i));
    req_op = (req_op & ~(12'h7 << (3 * i))) | (12'(op) << (3 * i));
  endtask

  task automatic rand_ops();
    req_a  = 16'($urandom);
    req_b  = 16'($urandom);
    req_op = 12'($urandom);
  endtask

  task automatic wait_acc(input int target, input int budget, input string tag);
    int n = 0;
    while (acc_count < target && n < budget) begin
      step();
      n++;
    end
    chk(tag, n < budget, 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while ((q.size() != 0 || busy) && n < budget) begin
      step();
      n++;
    end
    chk(tag, n < budget, 1'b1);
  endtask

  initial begin
    int base, s1, s2, r0, n;
    logic [4:0] held;
    logic [3:0] ra, rb;
    logic [2:0] rop;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single add request: 9 + 8 -> result 1, carry 1.
    set_op(0, 4'h9, 4'h8, 3'd0);
    req_valid = 4'b0001;
    wait_acc(acc_count + 1, 20, "t1_acc");
    req_valid = 4'h0;
    wait_idle(30, "t1_idle");
    chk("t1_id", last_id, 0);
    chk("t1_rc", last_rc, 5'h11);

    // All requesters continuously valid after a fresh reset: rotate 0,1,2,3,0.
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    base = acc_id_log.size();
    s1 = acc_count;
    req_valid = 4'hF;
    n = 0;
    while (acc_count < s1 + 5 && n < 80) begin
      rand_ops();
      step();
      n++;
    end
    req_valid = 4'h0;
    chk("t2_bound", n < 80, 1'b1);
    wait_idle(30, "t2_idle");
    for (int k = 0; k < 5; k++) begin
      if (base + k < acc_id_log.size()) chk("t2_id", acc_id_log[base + k], k % 4);
      else chk("t2_missing", 1'b0, 1'b1);
    end
    for (int k = 1; k < 5; k++) begin
      if (base + k < acc_cyc_log.size()) chk("t2_gap", acc_cyc_log[base + k] - acc_cyc_log[base + k - 1], ALU_LAT + 2);
      else chk("t2_gap_missing", 1'b0, 1'b1);
    end

    // Back-pressure: response held for 10 cycles while everyone else is requesting.
    set_op(3, 4'(($urandom)), 4'(($urandom)), 3'($urandom_range(0, 7)));
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    s1 = acc_count;
    wait_acc(s1 + 1, 20, "t3_acc");
    req_valid = 4'hF;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk("t3_resp", rsp_valid, 1'b1);
    held = {rsp_carry, rsp_result};
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t3_hold", {rsp_valid, rsp_carry, rsp_result, req_ready}, {1'b1, held, 4'h0});
      chk("t3_noacc", acc_count, s1 + 1);
    end
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    wait_idle(30, "t3_idle");
    chk("t3_id", last_id, 3);

    // req2 valid for a single idle cycle while req1 wins, then withdrawn.
    s1 = served[1];
    s2 = served[2];
    rand_ops();
    req_valid = 4'b0110;
    step();
    req_valid = 4'h0;
    wait_idle(30, "t4_idle");
    repeat (6) step();
    chk("t4_req1", served[1], s1 + 1);
    chk("t4_req2", served[2], s2);
    chk("t4_id", last_id, 1);

    // Reset during EXEC discards the operation; req0 is then served normally.
    rand_ops();
    req_valid = 4'b0001;
    wait_acc(acc_count + 1, 20, "t5_acc");
    req_valid = 4'h0;
    chk("t5_in_exec", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_now", {alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_result, rsp_carry, req_ready, busy}, 32'h0);
    step();
    rst_n = 1'b1;
    r0 = rsp_count;
    repeat (10) step();
    chk("t5_no_rsp", rsp_count, r0);
    ra = 4'($urandom);
    rb = 4'($urandom);
    rop = 3'($urandom_range(0, 7));
    set_op(0, ra, rb, rop);
    req_valid = 4'b0001;
    wait_acc(acc_count + 1, 20, "t5_acc2");
    req_valid = 4'h0;
    wait_idle(30, "t5_idle");
    chk("t5_id", last_id, 0);
    chk("t5_rc", last_rc, alu_f(rop, ra, rb));
    chk("t5_count", rsp_count, r0 + 1);

    // Random traffic with random back-pressure and dropped requests.
    r0 = rsp_count;
    repeat (400) begin
      req_valid = 4'($urandom_range(0, 15));
      rand_ops();
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    wait_idle(40, "rand_idle");
    chk("rand_progress", rsp_count > r0 + 20, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
